// File: rtl/cmerge2_cache_sync_if.sv
// rtl/cmerge2_cache_sync_if.sv - handshake bundle between two senders, the merger and the shared update stage
interface cmerge2_cache_sync_if;
    logic i_drive0;
    logic i_drive1;
    logic o_free0;
    logic o_free1;
    logic o_fire;
    logic o_sel;
    logic o_driveNext;
    logic i_freeNext;
    logic o_busy;
    logic o_err;

    modport master (
        output i_drive0, i_drive1, i_freeNext,
        input  o_free0, o_free1, o_fire, o_sel, o_driveNext, o_busy, o_err
    );

    modport slave (
        input  i_drive0, i_drive1, i_freeNext,
        output o_free0, o_free1, o_fire, o_sel, o_driveNext, o_busy, o_err
    );
endinterface

// File: rtl/cmerge2_cache_sync.sv
// rtl/cmerge2_cache_sync.sv - round-robin two-way drive/free request merger with fixed downstream delay
module cmerge2_cache_sync #(
    parameter int DRIVE_DELAY = 4
) (
    input logic                 clk,
    input logic                 rst,
    cmerge2_cache_sync_if.slave bus
);

    generate
        if (DRIVE_DELAY < 1 || DRIVE_DELAY > 15) begin : g_bad_delay
            $error("cmerge2_cache_sync: DRIVE_DELAY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_WAIT} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] pend_q, pend_d;
    logic       last_q, last_d;
    logic       sel_q, sel_d;
    logic       fire_q, fire_d;
    logic       drive_next_q, drive_next_d;
    logic [1:0] free_q, free_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

    logic [1:0] drive;
    logic [1:0] in_service;
    logic [1:0] viol;
    logic [1:0] grant_clr;
    logic       winner;
    logic       free_ok;

    assign drive = {bus.i_drive1, bus.i_drive0};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        sel_d        = sel_q;
        fire_d       = 1'b0;
        drive_next_d = 1'b0;
        free_d       = 2'b00;
        err_d        = err_q;
        grant_clr    = 2'b00;
        winner       = 1'b0;

        in_service = (state_q != S_IDLE) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
        viol       = drive & (pend_q | in_service);
        // downstream cannot complete in the same cycle it is driven
        free_ok    = (state_q == S_WAIT) && !drive_next_q;

        if (|viol) begin
            err_d = 1'b1;
        end
        if (bus.i_freeNext && !free_ok) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    winner            = (&pend_q) ? ~last_q : pend_q[1];
                    sel_d             = winner;
                    grant_clr[winner] = 1'b1;
                    fire_d            = 1'b1;
                    cnt_d             = 4'(DRIVE_DELAY - 1);
                    state_d           = S_DELAY;
                end
            end
            S_DELAY: begin
                if (cnt_q == 4'd0) begin
                    drive_next_d = 1'b1;
                    state_d      = S_WAIT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WAIT: begin
                if (bus.i_freeNext && free_ok) begin
                    free_d[sel_q] = 1'b1;
                    last_d        = sel_q;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pend_d = (pend_q & ~grant_clr) | (drive & ~viol);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            pend_q       <= 2'b00;
            last_q       <= 1'b1;
            sel_q        <= 1'b0;
            fire_q       <= 1'b0;
            drive_next_q <= 1'b0;
            free_q       <= 2'b00;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            last_q       <= last_d;
            sel_q        <= sel_d;
            fire_q       <= fire_d;
            drive_next_q <= drive_next_d;
            free_q       <= free_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign bus.o_free0     = free_q[0];
    assign bus.o_free1     = free_q[1];
    assign bus.o_fire      = fire_q;
    assign bus.o_sel       = sel_q;
    assign bus.o_driveNext = drive_next_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_err       = err_q;

endmodule
